// File: rtl/fe_pow_ctrl.sv
// Constant-time left-to-right square-and-multiply sequencer for GF(2^255-19).
// Drives one shared field multiplier; two multiplications per exponent bit regardless of exp.
//
// state    | meaning
// FLUSH    | post-reset drain of stale multiplier completions
// IDLE     | waiting for start
// SQ_ISSUE | pulse mul_start for acc*acc
// SQ_WAIT  | wait for the square
// MU_ISSUE | pulse mul_start for acc*b_r
// MU_WAIT  | wait for the multiply, keep or discard on e_r[idx]
// FIN      | done pulse, result valid
module fe_pow_ctrl #(
    parameter int EBITS = 255,
    parameter int DRAIN = 48
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [254:0]     base,
    input  logic [EBITS-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [254:0]     result,
    output logic             mul_start,
    output logic [254:0]     mul_a,
    output logic [254:0]     mul_b,
    input  logic             mul_done,
    input  logic [254:0]     mul_out
);

    localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam int DW = $clog2(DRAIN + 2);

    typedef enum logic [2:0] {
        FLUSH, IDLE, SQ_ISSUE, SQ_WAIT, MU_ISSUE, MU_WAIT, FIN
    } state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    drain_cnt, drain_nxt;
    logic [254:0]     acc, acc_nxt;
    logic [254:0]     b_r, b_nxt;
    logic [EBITS-1:0] e_r, e_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [254:0]     result_nxt;
    logic [254:0]     mu_sel;

    // The product is always computed; the exponent bit only steers a mux.
    assign mu_sel = e_r[idx] ? mul_out : acc;
    assign busy   = (state != IDLE);
    assign done   = (state == FIN);

    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        acc_nxt    = acc;
        b_nxt      = b_r;
        e_nxt      = e_r;
        idx_nxt    = idx;
        result_nxt = result;
        mul_start  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        case (state)
            FLUSH: begin
                if (drain_cnt != '0) drain_nxt = drain_cnt - DW'(1);
                if (drain_cnt <= DW'(1)) state_nxt = IDLE;
            end
            IDLE: begin
                if (start) begin
                    b_nxt     = base;
                    e_nxt     = exp;
                    acc_nxt   = 255'd1;
                    idx_nxt   = IW'(EBITS - 1);
                    state_nxt = SQ_ISSUE;
                end
            end
            SQ_ISSUE: begin
                mul_start = 1'b1;
                mul_a     = acc;
                mul_b     = acc;
                state_nxt = SQ_WAIT;
            end
            SQ_WAIT: begin
                mul_a = acc;
                mul_b = acc;
                if (mul_done) begin
                    acc_nxt   = mul_out;
                    state_nxt = MU_ISSUE;
                end
            end
            MU_ISSUE: begin
                mul_start = 1'b1;
                mul_a     = acc;
                mul_b     = b_r;
                state_nxt = MU_WAIT;
            end
            MU_WAIT: begin
                mul_a = acc;
                mul_b = b_r;
                if (mul_done) begin
                    acc_nxt = mu_sel;
                    if (idx == '0) begin
                        // Loaded on entry to FIN so result is valid while done is high.
                        result_nxt = mu_sel;
                        state_nxt  = FIN;
                    end else begin
                        idx_nxt   = idx - IW'(1);
                        state_nxt = SQ_ISSUE;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FLUSH;
            drain_cnt <= DW'(DRAIN);
            acc       <= '0;
            b_r       <= '0;
            e_r       <= '0;
            idx       <= '0;
            result    <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            acc       <= acc_nxt;
            b_r       <= b_nxt;
            e_r       <= e_nxt;
            idx       <= idx_nxt;
            result    <= result_nxt;
        end
    end

endmodule

// File: tb/tb_fe_pow_ctrl.sv
// Bench for fe_pow_ctrl: behavioural modular multiplier with programmable latency,
// table of directed exponentiations plus hand sequences for reset, drain and spurious completions.
module tb_fe_pow_ctrl;

    localparam int EBITS = 255;
    localparam int DRAIN = 48;
    localparam logic [254:0] P    = {255{1'b1}} - 255'd18;
    localparam logic [254:0] INV2 = {1'b0, {254{1'b1}}} - 255'd8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [254:0] base = '0;
    logic [254:0] exp = '0;
    logic         busy, done, mul_start, mul_done;
    logic [254:0] result, mul_a, mul_b, mul_out;

    fe_pow_ctrl #(.EBITS(EBITS), .DRAIN(DRAIN)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base(base), .exp(exp),
        .busy(busy), .done(done), .result(result),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_out(mul_out)
    );

    always #5 clock = ~clock;

    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] t;
        t = {255'b0, a} * {255'b0, b};
        t = t % {255'b0, P};
        return t[254:0];
    endfunction

    // Multiplier model: no reset, latency lat, optional injected completion.
    int           lat = 1;
    int           cnt = 0;
    logic         inj = 1'b0;
    logic [254:0] a_l = '0, b_l = '0, prod = '0;
    int           ms_cnt = 0, dbl_err = 0, stab_err = 0, rviol = 0;
    logic [254:0] prev_res = '0;
    logic         prev_rst = 1'b0;

    assign mul_done = (cnt == 1) || inj;
    assign mul_out  = prod;

    always @(posedge clock) begin
        if (mul_start) begin
            ms_cnt++;
            if (cnt != 0) dbl_err++;
            cnt  <= lat;
            a_l  <= mul_a;
            b_l  <= mul_b;
            prod <= mulmod(mul_a, mul_b);
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    always @(negedge clock) begin
        if (cnt != 0 && reset_n && (mul_a !== a_l || mul_b !== b_l)) stab_err++;
        if (reset_n && prev_rst && result !== prev_res && !done) rviol++;
        prev_res = result;
        prev_rst = reset_n;
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [254:0] act, input logic [254:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Called at the negedge of cycle 1; returns the cycle number in which done was seen.
    task automatic wait_done(input int l, output int n);
        int budget;
        budget = 1 + 2 * EBITS * (l + 1) + 20;
        n = 1;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Drives start for one edge; returns at the negedge of cycle 1.
    task automatic start_op(input logic [254:0] b, input logic [254:0] e);
        @(negedge clock);
        base  = b;
        exp   = e;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    typedef struct {
        logic [254:0] b;
        logic [254:0] e;
        int           l;
        logic [254:0] res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, ms0, g;
        logic [254:0] held, inv_res;

        vecs[0] = '{b: 255'd3,  e: 255'd2,         l: 5, res: 255'd9};
        vecs[1] = '{b: 255'd2,  e: P - 255'd2,     l: 1, res: INV2};
        vecs[2] = '{b: 255'd7,  e: 255'd0,         l: 1, res: 255'd1};
        vecs[3] = '{b: P - 255'd1, e: {255{1'b1}}, l: 1, res: P - 255'd1};
        vecs[4] = '{b: 255'd0,  e: 255'd5,         l: 1, res: 255'd0};
        vecs[5] = '{b: 255'd5,  e: 255'd3,         l: 3, res: 255'd125};
        inv_res = '0;

        // Reset, then release with start held high.
        reset_n = 1'b0; start = 1'b1; base = 255'd3; exp = 255'd2; lat = 1;
        repeat (3) @(negedge clock);
        chk("rst_busy", 255'(busy), 255'd1);
        chk("rst_done", 255'(done), 255'd0);
        chk("rst_mul_start", 255'(mul_start), 255'd0);
        chk("rst_mul_a", mul_a, 255'd0);
        chk("rst_mul_b", mul_b, 255'd0);
        chk("rst_result", result, 255'd0);
        ms0 = ms_cnt;
        #2 reset_n = 1'b1;
        #1;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk("flush_busy_cycles", 255'(n), 255'(DRAIN));
        chk("flush_no_mul_start", 255'(ms_cnt - ms0), 255'd0);
        @(negedge clock);
        chk("flush_then_accept_busy", 255'(busy), 255'd1);
        chk("flush_then_accept_mstart", 255'(mul_start), 255'd1);
        start = 1'b0;
        wait_done(1, n);
        chk("flush_op_latency", 255'(n), 255'(1 + 2 * EBITS * 2));
        chk("flush_op_result", result, 255'd9);

        // Start asserted during the done cycle is ignored; the following IDLE cycle accepts it.
        base = 255'd2; exp = 255'd2; start = 1'b1;
        @(negedge clock);
        chk("start_at_done_ignored", 255'(busy), 255'd0);
        @(negedge clock);
        chk("start_next_idle_busy", 255'(busy), 255'd1);
        chk("start_next_idle_mstart", 255'(mul_start), 255'd1);
        start = 1'b0;
        wait_done(1, n);
        chk("start_next_idle_result", result, 255'd4);

        for (int k = 0; k < 6; k++) begin
            lat  = vecs[k].l;
            held = result;
            ms0  = ms_cnt;
            start_op(vecs[k].b, vecs[k].e);
            chk($sformatf("v%0d_busy_c1", k), 255'(busy), 255'd1);
            chk($sformatf("v%0d_mstart_c1", k), 255'(mul_start), 255'd1);
            chk($sformatf("v%0d_result_held", k), result, held);
            wait_done(vecs[k].l, n);
            chk($sformatf("v%0d_latency", k), 255'(n), 255'(1 + 2 * EBITS * (vecs[k].l + 1)));
            chk($sformatf("v%0d_result", k), result, vecs[k].res);
            chk($sformatf("v%0d_mul_starts", k), 255'(ms_cnt - ms0), 255'(2 * EBITS));
            if (k == 1) inv_res = result;
            @(negedge clock);
            chk($sformatf("v%0d_idle_after", k), 255'({busy, done}), 255'd0);
        end
        chk("inverse_times_two", mulmod(255'd2, inv_res), 255'd1);

        // Spurious completions in IDLE and in an ISSUE cycle.
        lat  = 2;
        held = result;
        ms0  = ms_cnt;
        @(negedge clock);
        inj = 1'b1;
        @(negedge clock);
        inj = 1'b0;
        chk("spur_idle_busy", 255'(busy), 255'd0);
        chk("spur_idle_result", result, held);
        start_op(255'd3, 255'd2);
        inj = 1'b1;
        @(negedge clock);
        inj = 1'b0;
        n = 0;
        wait_done(2, n);
        chk("spur_issue_latency", 255'(n + 1), 255'(1 + 2 * EBITS * 3));
        chk("spur_issue_result", result, 255'd9);
        chk("spur_mul_starts", 255'(ms_cnt - ms0), 255'(2 * EBITS));

        // Reset asserted mid-MU_WAIT, then a fresh operation.
        lat = 5;
        ms0 = ms_cnt;
        start_op(255'd3, 255'd3);
        g = 0;
        while ((ms_cnt - ms0) < 2 && g < 50) begin
            @(negedge clock);
            g++;
        end
        chk("midrst_reached_mu_wait", 255'({busy, mul_start, 1'(g < 50)}), 255'b101);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 255'(busy), 255'd1);
        chk("midrst_done", 255'(done), 255'd0);
        chk("midrst_mul_start", 255'(mul_start), 255'd0);
        chk("midrst_mul_ab", mul_a | mul_b, 255'd0);
        chk("midrst_result", result, 255'd0);
        repeat (8) @(negedge clock);
        #2 reset_n = 1'b1;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clock);
            g++;
        end
        chk("midrst_flush_len", 255'(g), 255'(DRAIN));
        lat = 3;
        ms0 = ms_cnt;
        start_op(255'd5, 255'd3);
        wait_done(3, n);
        chk("midrst_fresh_result", result, 255'd125);
        chk("midrst_fresh_latency", 255'(n), 255'(1 + 2 * EBITS * 4));
        chk("midrst_fresh_mul_starts", 255'(ms_cnt - ms0), 255'(2 * EBITS));

        repeat (3) @(negedge clock);
        chk("no_double_issue", 255'(dbl_err), 255'd0);
        chk("operands_stable", 255'(stab_err), 255'd0);
        chk("result_changes_only_done", 255'(rviol), 255'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
